// File: rtl/tri_bus_pkg.sv
// ============================================================================
// tri_bus_pkg - shared types and helpers for the tri-state bus arbiter. Rev 1.0
// ============================================================================
`default_nettype none

package tri_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN  = 2'd1,
      ST_TURN = 2'd2
   } state_t;

   // Turnaround counter covers TA_CYCLES up to 15.
   localparam int TA_W = 4;

   // Ceiling log2, never below 1 so derived vectors always have a bit.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      if (r == 0) r = 1;
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// rr_pick - combinational round-robin selector starting at ptr. Rev 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
   parameter int NREQ = 4,
   parameter int IDXW = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDXW-1:0] ptr,
   input  logic [NREQ-1:0] mask,
   output logic            valid,
   output logic [IDXW-1:0] idx
);

   logic [IDXW-1:0] cand;

   always_comb begin
      valid = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = IDXW'((int'(ptr) + i) % NREQ);
         if (!valid && req[cand] && !mask[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/tri_bus_arbiter.sv
// ============================================================================
// tri_bus_arbiter - round-robin owner of a shared tri-state pad bus. Rev 1.0
// ============================================================================
`default_nettype none

module tri_bus_arbiter
   import tri_bus_pkg::*;
#(
   parameter int NREQ      = 4,
   parameter int TA_CYCLES = 1,
   parameter int MAX_HOLD  = 16,
   parameter int IDXW      = clog2(NREQ)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] rel,
   output logic [NREQ-1:0] gnt,
   output logic            oe,
   output logic [IDXW-1:0] sel,
   output logic            busy
);

   localparam int HOLD_W = clog2(MAX_HOLD + 1);
   localparam logic [TA_W-1:0] TA_LOAD = (TA_CYCLES > 0) ? TA_W'(TA_CYCLES - 1) : '0;

   state_t            state;
   logic [IDXW-1:0]   ptr;
   logic [HOLD_W-1:0] hold;
   logic [TA_W-1:0]   ta;

   logic [IDXW-1:0]   next_ptr;
   logic [IDXW-1:0]   pick_ptr;
   logic [NREQ-1:0]   pick_mask;
   logic              pick_valid;
   logic [IDXW-1:0]   pick_idx;
   logic [NREQ-1:0]   pick_onehot;
   logic              hold_hit;
   logic              own_exit;

   assign next_ptr    = (sel == IDXW'(NREQ - 1)) ? '0 : sel + IDXW'(1);
   // While owning, the only arbitration that matters is the zero-turnaround
   // hand-off, which starts after the leaving owner and must skip it.
   assign pick_ptr    = (state == ST_OWN) ? next_ptr : ptr;
   assign pick_mask   = (TA_CYCLES == 0 && state == ST_OWN) ? gnt : '0;
   assign pick_onehot = NREQ'(1) << pick_idx;
   assign hold_hit    = (MAX_HOLD != 0) && (hold == HOLD_W'(MAX_HOLD));
   assign own_exit    = rel[sel] || !req[sel] || hold_hit;

   rr_pick #(
      .NREQ (NREQ),
      .IDXW (IDXW)
   ) u_pick (
      .req   (req),
      .ptr   (pick_ptr),
      .mask  (pick_mask),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         gnt   <= '0;
         oe    <= 1'b0;
         sel   <= '0;
         busy  <= 1'b0;
         ptr   <= '0;
         hold  <= '0;
         ta    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_valid) begin
                  state <= ST_OWN;
                  sel   <= pick_idx;
                  gnt   <= pick_onehot;
                  oe    <= 1'b1;
                  busy  <= 1'b1;
                  hold  <= HOLD_W'(1);
               end
            end
            ST_OWN: begin
               if (own_exit) begin
                  ptr <= next_ptr;
                  if (TA_CYCLES > 0) begin
                     state <= ST_TURN;
                     gnt   <= '0;
                     oe    <= 1'b0;
                     ta    <= TA_LOAD;
                  end else if (pick_valid) begin
                     sel  <= pick_idx;
                     gnt  <= pick_onehot;
                     hold <= HOLD_W'(1);
                  end else begin
                     state <= ST_IDLE;
                     gnt   <= '0;
                     oe    <= 1'b0;
                     busy  <= 1'b0;
                  end
               end else if (hold != '1) begin
                  hold <= hold + HOLD_W'(1);
               end
            end
            ST_TURN: begin
               if (ta != '0) begin
                  ta <= ta - TA_W'(1);
               end else if (pick_valid) begin
                  state <= ST_OWN;
                  sel   <= pick_idx;
                  gnt   <= pick_onehot;
                  oe    <= 1'b1;
                  hold  <= HOLD_W'(1);
               end else begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   a_oe_matches_gnt: assert property (@(posedge clk) disable iff (rst) oe == |gnt);
   a_gnt_onehot0:    assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));

endmodule

`default_nettype wire

// File: tb/tb_tri_bus_arbiter.sv
// ============================================================================
// tb_tri_bus_arbiter - directed vector bench over four parameterisations. Rev 1.0
// ============================================================================
`default_nettype none

module tb_tri_bus_arbiter;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] rel;
      logic [3:0] gnt;
      logic       oe;
      logic [1:0] sel;
      logic       busy;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // a: TA=1, MAX_HOLD=16   b: TA=2, MAX_HOLD=3   c: TA=0   d: MAX_HOLD=0
   logic       rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1, rst_d = 1'b1;
   logic [3:0] req_a = '0, req_b = '0, req_c = '0, req_d = '0;
   logic [3:0] rel_a = '0, rel_b = '0, rel_c = '0, rel_d = '0;
   logic [3:0] gnt_a, gnt_b, gnt_c, gnt_d;
   logic       oe_a, oe_b, oe_c, oe_d;
   logic [1:0] sel_a, sel_b, sel_c, sel_d;
   logic       busy_a, busy_b, busy_c, busy_d;

   tri_bus_arbiter #(.NREQ(4), .TA_CYCLES(1), .MAX_HOLD(16)) u_a (
      .clk(clk), .rst(rst_a), .req(req_a), .rel(rel_a),
      .gnt(gnt_a), .oe(oe_a), .sel(sel_a), .busy(busy_a));

   tri_bus_arbiter #(.NREQ(4), .TA_CYCLES(2), .MAX_HOLD(3)) u_b (
      .clk(clk), .rst(rst_b), .req(req_b), .rel(rel_b),
      .gnt(gnt_b), .oe(oe_b), .sel(sel_b), .busy(busy_b));

   tri_bus_arbiter #(.NREQ(4), .TA_CYCLES(0), .MAX_HOLD(16)) u_c (
      .clk(clk), .rst(rst_c), .req(req_c), .rel(rel_c),
      .gnt(gnt_c), .oe(oe_c), .sel(sel_c), .busy(busy_c));

   tri_bus_arbiter #(.NREQ(4), .TA_CYCLES(1), .MAX_HOLD(0)) u_d (
      .clk(clk), .rst(rst_d), .req(req_d), .rel(rel_d),
      .gnt(gnt_d), .oe(oe_d), .sel(sel_d), .busy(busy_d));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   vec_t vecs [16];

   initial begin
      // Each row: inputs before an edge, outputs expected just after it.
      vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0}; // reset
      vecs[1]  = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b1}; // grant 0
      vecs[2]  = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b1};
      vecs[3]  = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b1};
      vecs[4]  = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b1}; // REL[0] -> TURN
      vecs[5]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0}; // -> IDLE
      vecs[6]  = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b1}; // grant 2
      vecs[7]  = '{1'b0, 4'b1100, 4'b0010, 4'b0100, 1'b1, 2'd2, 1'b1}; // non-owner REL
      vecs[8]  = '{1'b0, 4'b1000, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b1}; // owner drops REQ
      vecs[9]  = '{1'b0, 4'b1000, 4'b0000, 4'b1000, 1'b1, 2'd3, 1'b1}; // grant 3
      vecs[10] = '{1'b1, 4'b1000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0}; // reset mid-OWN
      vecs[11] = '{1'b0, 4'b1010, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b1}; // ptr back at 0
      vecs[12] = '{1'b0, 4'b1010, 4'b0010, 4'b0000, 1'b0, 2'd1, 1'b1}; // release 1
      vecs[13] = '{1'b0, 4'b1011, 4'b0000, 4'b1000, 1'b1, 2'd3, 1'b1}; // from ptr 2 -> 3
      vecs[14] = '{1'b0, 4'b0011, 4'b0000, 4'b0000, 1'b0, 2'd3, 1'b1}; // 3 drops REQ
      vecs[15] = '{1'b0, 4'b0011, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b1}; // ptr wraps to 0

      step();
      check("b_reset_gnt", 32'(gnt_b), 32'h0);
      check("b_reset_oe", 32'(oe_b), 32'h0);
      check("c_reset_busy", 32'(busy_c), 32'h0);

      // Table for TA=1 instance: single owner, non-owner REL, reset, wrap.
      for (int i = 0; i < 16; i++) begin
         rst_a = vecs[i].rst;
         req_a = vecs[i].req;
         rel_a = vecs[i].rel;
         step();
         rel_a = '0;
         check($sformatf("a_vec%0d_gnt", i), 32'(gnt_a), 32'(vecs[i].gnt));
         check($sformatf("a_vec%0d_oe", i), 32'(oe_a), 32'(vecs[i].oe));
         check($sformatf("a_vec%0d_sel", i), 32'(sel_a), 32'(vecs[i].sel));
         check($sformatf("a_vec%0d_busy", i), 32'(busy_a), 32'(vecs[i].busy));
      end

      // Hold limit 3, turnaround 2: owners 0,1,2,3,0 in order.
      rst_b = 1'b0;
      req_b = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("b_t%0d_c%0d_gnt", k, c), 32'(gnt_b), 32'(4'b0001 << (k % 4)));
            check($sformatf("b_t%0d_c%0d_oe", k, c), 32'(oe_b), 32'h1);
            check($sformatf("b_t%0d_c%0d_sel", k, c), 32'(sel_b), 32'(k % 4));
         end
         if (k < 4) begin
            for (int c = 0; c < 2; c++) begin
               step();
               check($sformatf("b_t%0d_ta%0d_oe", k, c), 32'({oe_b, gnt_b}), 32'h0);
               check($sformatf("b_t%0d_ta%0d_busy", k, c), 32'(busy_b), 32'h1);
            end
         end
      end

      // Zero turnaround: direct hand-off, and masked leaving owner.
      rst_c = 1'b0;
      req_c = 4'b0011;
      for (int c = 0; c < 3; c++) begin
         step();
         check($sformatf("c_own0_c%0d", c), 32'({oe_c, gnt_c}), 32'h11);
      end
      rel_c = 4'b0001;
      step();
      rel_c = '0;
      check("c_handoff_gnt_oe", 32'({oe_c, gnt_c}), 32'h12);
      check("c_handoff_sel", 32'(sel_c), 32'h1);
      step();
      check("c_own1_held", 32'({oe_c, gnt_c}), 32'h12);
      rel_c = 4'b0010;
      step();
      rel_c = '0;
      check("c_handoff_back", 32'({oe_c, gnt_c, 2'b00, sel_c}), 32'h110);
      req_c = 4'b0001;
      rel_c = 4'b0001;
      step();
      rel_c = '0;
      check("c_masked_idle", 32'({busy_c, oe_c, gnt_c}), 32'h0);
      check("c_idle_sel_kept", 32'(sel_c), 32'h0);

      // Unlimited hold: a lone requester keeps the bus indefinitely.
      rst_d = 1'b0;
      req_d = 4'b0100;
      for (int c = 0; c < 100; c++) begin
         step();
         check($sformatf("d_hold_c%0d", c), 32'({busy_d, oe_d, gnt_d}), 32'h34);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
